rs_alu_issue: RTL and testbench
===============================

// Module: rs_alu_issue
// PURPOSE
//  ALU reservation station: the issue side of the RS->ALU interface. Buffers dispatched ALU ops
//  (rs_data), tracks source-operand readiness from writeback wakeups, picks the oldest ready entry
//  and presents it with `issued` to fu_alu, whose PRF operands are read the same cycle. Squashes
//  wrong-path entries on mispredict using the same ROB-window rule as the FUs.
// PARAMETERS
//  DEPTH      8   RS entries (power of 2, 2..16)
//  ROB_DEPTH  16  ROB entries; tag wraps 15->0
//  TAG_W      5   ROB tag width
//  PREG_W     7   physical register index width; preg 0 is hardwired zero
// PORTS
//  clk             in   1       clock
//  reset           in   1       synchronous, active-high reset
//  disp_valid      in   1       dispatch request this cycle
//  disp_data       in   rs_data op to buffer (pd, ps1, ps2, ps1_ready, ps2_ready, rob_index, Opcode, func3, func7, imm)
//  rs_ready        out  1       space available; registered, = (count < DEPTH)
//  wk_valid        in   2       per-port wakeup strobe (0: ALU writeback, 1: other FU/CDB)
//  wk_preg         in   2xPREG_W  physical reg produced on each wakeup port
//  fu_ready        in   1       fu_alu_ready from fu_alu
//  issued          out  1       data_out valid this cycle (one-cycle pulse per op)
//  data_out        out  rs_data issued op; ps1/ps2 drive PRF read addresses
//  rob_head        in   TAG_W   oldest in-flight ROB tag (age reference)
//  curr_rob_tag    in   TAG_W   ROB tail (next tag to allocate)
//  mispredict      in   1       flush strobe, single cycle
//  mispredict_tag  in   TAG_W   ROB tag of mispredicted branch
// BEHAVIOUR
//  Reset: all entry valid bits 0, count 0, rs_ready 1, issued 0, data_out '0. Reset mid-operation
//   discards every entry and any pending issue; no op leaves after reset assertion.
//  Dispatch: disp_valid & rs_ready & !mispredict -> write into lowest free slot at clock edge.
//   disp_valid while rs_ready=0 is ignored (dispatcher must not do this; assertion flags it).
//   Operand ready on write = disp ready bit | (ps==0) | match on any wk_valid port same cycle.
//  Wakeup: each cycle every valid entry with ps1/ps2 == wk_preg[k] & wk_valid[k] sets that ready bit
//   at the edge. Wakeup affects selection from the next cycle (no same-cycle wakeup->select).
//  Select: candidates = valid & ps1_ready & ps2_ready. Oldest = min (rob_index - rob_head) mod
//   ROB_DEPTH; ties impossible (unique rob_index). Only when fu_ready=1.
//  Issue: latency 1. Selected entry is copied to the data_out register and freed at the edge;
//   issued=1 the following cycle, for exactly one cycle. Back-to-back issue each cycle allowed.
//   fu_ready=0 -> no selection, issued=0 next cycle, entries retained.
//  Count: count_next = count + dispatched - issued_now - squashed; rs_ready from registered count,
//   so a full RS issuing this cycle accepts dispatch only next cycle.
//  Flush: flush window = tags from mispredict_tag+1 (wrap 15->0) up to, excluding, curr_rob_tag.
//   mispredict=1 -> at the edge clear every entry whose rob_index is in the window; no select
//   that cycle; dispatch dropped; data_out register cleared and issued=0 next cycle if its op is
//   in the window. Branch itself and older ops are retained. Empty window (mispredict_tag+1 ==
//   curr_rob_tag) squashes nothing.
//  Simultaneous wakeup+flush: flush wins for squashed entries; survivors take the wakeup.
//  Empty RS: issued=0, data_out holds last value (don't-care when issued=0).
// STRUCTURE
//  types_pkg: rs_data (existing), RS_DEPTH/ROB_DEPTH constants, function
//   rob_in_window(tag, lo_excl, hi_excl) shared with the FUs for the flush rule, function
//   rob_age(tag, head) = (tag-head) mod ROB_DEPTH.
//  Sub-module rs_age_select: DEPTH ready bits + ages -> one-hot grant + valid; pure comb.
//  Top holds entry array, free-slot encoder, wakeup compare, flush mask, issue register.
// TESTING
//  1 Reset then dispatch addi (ps1=5 ready, rob 3), fu_ready=1 -> issued=1 two edges later,
//    data_out.rob_index=3, rs_ready stays 1.
//  2 Dispatch sub rob 4 (ps2=9 not ready), then and rob 6 ready -> and issues first; wk_preg=9
//    at cycle N -> sub issues with issued=1 at N+2, not N+1.
//  3 Fill 8 entries, none ready -> rs_ready=0 after 8th; 9th disp_valid ignored; wake one -> it
//    issues, rs_ready returns 1 the cycle after the issue.
//  4 rob_head=14, ready ops rob 1 and rob 15 -> rob 15 issues first (wrap-around age).
//  5 Entries rob 2,3,5,7; curr_rob_tag=8, mispredict_tag=3 -> rob 5,7 squashed, 2,3 remain;
//    concurrent dispatch dropped; count 4->2.
//  6 fu_ready=0 for 3 cycles with 2 ready entries -> issued=0 throughout; both issue on the two
//    cycles after fu_ready returns, oldest first; reset asserted mid-stream -> issued=0 next cycle.

Source files
------------

// File: rtl/rs_alu_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_alu_issue_pkg
// Description : Shared types and ROB-tag helpers for the ALU reservation
//               station: rs_data payload, sizing constants, and the age and
//               flush-window functions also used by the functional units.
// Revision    : 1.0 - initial release
// ============================================================================
package rs_alu_issue_pkg;

  localparam int RS_DEPTH  = 8;
  localparam int ROB_DEPTH = 16;
  localparam int TAG_W     = 5;
  localparam int PREG_W    = 7;

  // Dispatched ALU op as held in the reservation station
  typedef struct packed {
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic              ps1_ready;
    logic              ps2_ready;
    logic [TAG_W-1:0]  rob_index;
    logic [6:0]        Opcode;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic [31:0]       imm;
  } rs_data;

  // Distance of a tag from the ROB head, modulo ROB_DEPTH (0 = oldest)
  function automatic logic [TAG_W-1:0] rob_age(input logic [TAG_W-1:0] tag,
                                               input logic [TAG_W-1:0] head);
    logic [TAG_W:0] sum;
    sum = {1'b0, tag} + (TAG_W+1)'(ROB_DEPTH) - {1'b0, head};
    if (sum >= (TAG_W+1)'(ROB_DEPTH)) begin
      sum = sum - (TAG_W+1)'(ROB_DEPTH);
    end
    return sum[TAG_W-1:0];
  endfunction

  // True when tag lies strictly between lo_excl and hi_excl going forward
  // around the ROB; lo_excl+1 == hi_excl gives an empty window.
  function automatic logic rob_in_window(input logic [TAG_W-1:0] tag,
                                         input logic [TAG_W-1:0] lo_excl,
                                         input logic [TAG_W-1:0] hi_excl);
    logic [TAG_W-1:0] a;
    logic [TAG_W-1:0] h;
    a = rob_age(tag, lo_excl);
    h = rob_age(hi_excl, lo_excl);
    return (a != '0) && (a < h);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs_age_select.sv
`default_nettype none
// ============================================================================
// Module      : rs_age_select
// Description : Picks the requesting entry with the smallest ROB age and
//               returns it as a one-hot grant. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_age_select
  import rs_alu_issue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]            i_req,
  input  logic [DEPTH-1:0][TAG_W-1:0] i_age,
  output logic [DEPTH-1:0]            o_grant,
  output logic                        o_valid
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             w_found;
  logic [TAG_W-1:0] w_best_age;
  logic [IDX_W-1:0] w_best_idx;

  // Linear min-search over requesters; unique tags mean no tie-break needed
  always_comb begin
    w_found    = 1'b0;
    w_best_age = '0;
    w_best_idx = '0;
    o_grant    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_req[i] && (!w_found || (i_age[i] < w_best_age))) begin
        w_found    = 1'b1;
        w_best_age = i_age[i];
        w_best_idx = IDX_W'(i);
      end
    end
    if (w_found) begin
      o_grant[w_best_idx] = 1'b1;
    end
    o_valid = w_found;
  end

endmodule
`default_nettype wire

// File: rtl/rs_alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : rs_alu_issue
// Description : ALU reservation station. Buffers dispatched ops, tracks
//               operand readiness from writeback wakeups, issues the oldest
//               ready op through a one-cycle issue register, and squashes
//               wrong-path entries on mispredict.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_alu_issue
  import rs_alu_issue_pkg::*;
#(
  parameter int DEPTH         = RS_DEPTH,
  parameter bit DISP_CHECK_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_disp_valid,
  input  rs_data                 i_disp_data,
  output logic                   o_rs_ready,
  input  logic [1:0]             i_wk_valid,
  input  logic [1:0][PREG_W-1:0] i_wk_preg,
  input  logic                   i_fu_ready,
  output logic                   o_issued,
  output rs_data                 o_data_out,
  input  logic [TAG_W-1:0]       i_rob_head,
  input  logic [TAG_W-1:0]       i_curr_rob_tag,
  input  logic                   i_mispredict,
  input  logic [TAG_W-1:0]       i_mispredict_tag
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  rs_data             r_ent [DEPTH];
  logic [DEPTH-1:0]   r_valid;
  logic [CNT_W-1:0]   r_count;
  logic               r_rs_ready;
  logic               r_issued;
  rs_data             r_data_out;

  logic [DEPTH-1:0]            w_req;
  logic [DEPTH-1:0][TAG_W-1:0] w_age;
  logic [DEPTH-1:0]            w_grant;
  logic                        w_sel_valid;
  rs_data                      w_sel_data;
  logic [DEPTH-1:0]            w_flush;
  logic [DEPTH-1:0]            w_wk1;
  logic [DEPTH-1:0]            w_wk2;
  logic [IDX_W-1:0]            w_free_idx;
  logic                        w_has_free;
  logic                        w_disp_fire;
  rs_data                      w_disp_ent;
  logic [CNT_W-1:0]            w_flush_cnt;
  logic [CNT_W-1:0]            w_count_next;

  // Any wakeup port producing this physical register this cycle
  function automatic logic wk_hit(input logic [PREG_W-1:0]      ps,
                                  input logic [1:0]             v,
                                  input logic [1:0][PREG_W-1:0] p);
    return (v[0] && (p[0] == ps)) || (v[1] && (p[1] == ps));
  endfunction

  // Per-entry age, wakeup match, flush membership and select request
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    assign w_age[g]   = rob_age(r_ent[g].rob_index, i_rob_head);
    assign w_wk1[g]   = wk_hit(r_ent[g].ps1, i_wk_valid, i_wk_preg);
    assign w_wk2[g]   = wk_hit(r_ent[g].ps2, i_wk_valid, i_wk_preg);
    assign w_flush[g] = i_mispredict & r_valid[g] &
                        rob_in_window(r_ent[g].rob_index, i_mispredict_tag, i_curr_rob_tag);
    assign w_req[g]   = r_valid[g] & r_ent[g].ps1_ready & r_ent[g].ps2_ready &
                        i_fu_ready & ~i_mispredict;
  end

  rs_age_select #(
    .DEPTH (DEPTH)
  ) u_select (
    .i_req   (w_req),
    .i_age   (w_age),
    .o_grant (w_grant),
    .o_valid (w_sel_valid)
  );

  // One-hot mux of the granted entry
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) begin
        w_sel_data = r_ent[i];
      end
    end
  end

  // Lowest free slot; scanning downward leaves the lowest index last
  always_comb begin
    w_free_idx = '0;
    w_has_free = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_idx = IDX_W'(i);
        w_has_free = 1'b1;
      end
    end
  end

  // Dispatch accept and operand readiness at write (preg 0 and same-cycle wakeups)
  always_comb begin
    w_disp_fire          = i_disp_valid & r_rs_ready & ~i_mispredict & w_has_free;
    w_disp_ent           = i_disp_data;
    w_disp_ent.ps1_ready = i_disp_data.ps1_ready | (i_disp_data.ps1 == '0) |
                           wk_hit(i_disp_data.ps1, i_wk_valid, i_wk_preg);
    w_disp_ent.ps2_ready = i_disp_data.ps2_ready | (i_disp_data.ps2 == '0) |
                           wk_hit(i_disp_data.ps2, i_wk_valid, i_wk_preg);
  end

  // Occupancy bookkeeping: in a flush cycle there is no dispatch and no select
  always_comb begin
    w_flush_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_flush_cnt = w_flush_cnt + CNT_W'(w_flush[i]);
    end
    w_count_next = r_count + CNT_W'(w_disp_fire) - CNT_W'(w_sel_valid) - w_flush_cnt;
  end

  // Entry valid bits: squash and issue free a slot, dispatch claims one
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_flush[i] || w_grant[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
      if (w_disp_fire) begin
        r_valid[w_free_idx] <= 1'b1;
      end
    end
  end

  // Entry payload: wakeups set ready bits on live entries, dispatch writes the free slot
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && !w_flush[i]) begin
        if (w_wk1[i]) begin
          r_ent[i].ps1_ready <= 1'b1;
        end
        if (w_wk2[i]) begin
          r_ent[i].ps2_ready <= 1'b1;
        end
      end
    end
    if (w_disp_fire) begin
      r_ent[w_free_idx] <= w_disp_ent;
    end
  end

  // Issue register: one-cycle pulse per selected op; a squashed op is wiped
  always_ff @(posedge clk) begin
    if (reset) begin
      r_issued   <= 1'b0;
      r_data_out <= '0;
    end else if (i_mispredict) begin
      r_issued <= 1'b0;
      if (rob_in_window(r_data_out.rob_index, i_mispredict_tag, i_curr_rob_tag)) begin
        r_data_out <= '0;
      end
    end else if (w_sel_valid) begin
      r_issued   <= 1'b1;
      r_data_out <= w_sel_data;
    end else begin
      r_issued <= 1'b0;
    end
  end

  // Occupancy count and registered space-available flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_rs_ready <= 1'b1;
    end else begin
      r_count    <= w_count_next;
      r_rs_ready <= (w_count_next < CNT_W'(DEPTH));
    end
  end

  // Dispatcher must never present an op while the station is full
  always_ff @(posedge clk) begin
    if (!reset && DISP_CHECK_EN) begin
      assert (!(i_disp_valid && !r_rs_ready));
    end
  end

  assign o_rs_ready = r_rs_ready;
  assign o_issued   = r_issued;
  assign o_data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_rs_alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_alu_issue
// Description : Directed bench for rs_alu_issue with an in-order expected
//               issue queue checked whenever the station issues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_alu_issue;
  import rs_alu_issue_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   i_disp_valid;
  rs_data                 i_disp_data;
  logic                   o_rs_ready;
  logic [1:0]             i_wk_valid;
  logic [1:0][PREG_W-1:0] i_wk_preg;
  logic                   i_fu_ready;
  logic                   o_issued;
  rs_data                 o_data_out;
  logic [TAG_W-1:0]       i_rob_head;
  logic [TAG_W-1:0]       i_curr_rob_tag;
  logic                   i_mispredict;
  logic [TAG_W-1:0]       i_mispredict_tag;

  rs_data exp_q[$];
  int     tests = 0;
  int     fails = 0;

  // The full-RS dispatch check is disabled so the bench can probe that case
  rs_alu_issue #(
    .DEPTH         (8),
    .DISP_CHECK_EN (1'b0)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i_disp_valid     (i_disp_valid),
    .i_disp_data      (i_disp_data),
    .o_rs_ready       (o_rs_ready),
    .i_wk_valid       (i_wk_valid),
    .i_wk_preg        (i_wk_preg),
    .i_fu_ready       (i_fu_ready),
    .o_issued         (o_issued),
    .o_data_out       (o_data_out),
    .i_rob_head       (i_rob_head),
    .i_curr_rob_tag   (i_curr_rob_tag),
    .i_mispredict     (i_mispredict),
    .i_mispredict_tag (i_mispredict_tag)
  );

  always #5 clk = ~clk;

  function automatic rs_data mk(input int pd, input int ps1, input int ps2,
                                input bit r1, input bit r2, input int rob);
    rs_data d;
    d           = '0;
    d.pd        = PREG_W'(pd);
    d.ps1       = PREG_W'(ps1);
    d.ps2       = PREG_W'(ps2);
    d.ps1_ready = r1;
    d.ps2_ready = r2;
    d.rob_index = TAG_W'(rob);
    d.Opcode    = 7'h33;
    d.func3     = 3'(rob);
    d.func7     = 7'h20;
    d.imm       = 32'(1000 + rob);
    return d;
  endfunction

  // An issued op always has both operands ready
  function automatic rs_data as_issued(input rs_data d);
    rs_data r;
    r           = d;
    r.ps1_ready = 1'b1;
    r.ps2_ready = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic dispatch(input rs_data d);
    i_disp_valid = 1'b1;
    i_disp_data  = d;
    tick();
    i_disp_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard: every issue must match the next expected op, in order
  always @(negedge clk) begin
    rs_data e;
    if (o_issued === 1'b1) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_issue: observed rob %0d expected no issue", o_data_out.rob_index);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        tests++;
        assert (o_data_out === e) else begin
          fails++;
          $error("FAIL issue_data: observed %h expected %h", o_data_out, e);
        end
      end
    end
  end

  initial begin
    rs_data d_a;
    rs_data d_b;
    i_disp_valid     = 1'b0;
    i_disp_data      = '0;
    i_wk_valid       = '0;
    i_wk_preg        = '0;
    i_fu_ready       = 1'b1;
    i_rob_head       = '0;
    i_curr_rob_tag   = '0;
    i_mispredict     = 1'b0;
    i_mispredict_tag = '0;

    // Reset state
    tick();
    tick();
    chk("rst_issued", o_issued, 1'b0);
    chk("rst_rs_ready", o_rs_ready, 1'b1);
    chk("rst_data_out", o_data_out, '0);
    reset = 1'b0;

    // 1: single ready op, latency two edges from dispatch; ps2=0 counts as ready
    d_a = mk(1, 5, 0, 1'b1, 1'b0, 3);
    exp_q.push_back(as_issued(d_a));
    dispatch(d_a);
    chk("t1_issued_early", o_issued, 1'b0);
    tick();
    chk("t1_issued", o_issued, 1'b1);
    chk("t1_rob", o_data_out.rob_index, 5'd3);
    chk("t1_rs_ready", o_rs_ready, 1'b1);
    tick();
    chk("t1_pulse_end", o_issued, 1'b0);

    // 2: blocked older op, younger ready op goes first; wakeup -> issue at N+2
    d_a = mk(2, 3, 9, 1'b1, 1'b0, 4);
    d_b = mk(3, 10, 11, 1'b1, 1'b1, 6);
    exp_q.push_back(as_issued(d_b));
    exp_q.push_back(as_issued(d_a));
    dispatch(d_a);
    dispatch(d_b);
    tick();
    chk("t2_and_issued", o_issued, 1'b1);
    i_wk_valid   = 2'b10;
    i_wk_preg[1] = 7'd9;
    tick();
    i_wk_valid = '0;
    chk("t2_n1_no_issue", o_issued, 1'b0);
    tick();
    chk("t2_n2_issue", o_issued, 1'b1);
    tick();
    chk("t2_idle", o_issued, 1'b0);

    // 3: fill to full, ignored 9th dispatch, wake one entry
    for (int i = 0; i < 8; i++) begin
      dispatch(mk(4, 20 + i, 0, 1'b0, 1'b1, i));
      chk("t3_fill_rs_ready", o_rs_ready, (i < 7) ? 1'b1 : 1'b0);
    end
    exp_q.push_back(as_issued(mk(4, 23, 0, 1'b0, 1'b1, 3)));
    dispatch(mk(5, 0, 0, 1'b1, 1'b1, 8));
    chk("t3_full_rs_ready", o_rs_ready, 1'b0);
    i_wk_valid   = 2'b01;
    i_wk_preg[0] = 7'd23;
    tick();
    i_wk_valid = '0;
    chk("t3_no_issue_of_ignored", o_issued, 1'b0);
    chk("t3_still_full", o_rs_ready, 1'b0);
    tick();
    chk("t3_woken_issued", o_issued, 1'b1);
    chk("t3_rs_ready_back", o_rs_ready, 1'b1);
    tick();
    chk("t3_idle", o_issued, 1'b0);
    do_reset();

    // 4: wrap-around age with rob_head=14; rob 1 also woken on dispatch cycle
    i_rob_head = 5'd14;
    i_fu_ready = 1'b0;
    d_a = mk(6, 50, 0, 1'b0, 1'b0, 1);
    d_b = mk(7, 51, 52, 1'b1, 1'b1, 15);
    exp_q.push_back(as_issued(d_b));
    exp_q.push_back(as_issued(d_a));
    i_wk_valid   = 2'b01;
    i_wk_preg[0] = 7'd50;
    dispatch(d_a);
    i_wk_valid = '0;
    dispatch(d_b);
    chk("t4_held", o_issued, 1'b0);
    i_fu_ready = 1'b1;
    tick();
    chk("t4_first_issued", o_issued, 1'b1);
    chk("t4_first_rob", o_data_out.rob_index, 5'd15);
    tick();
    chk("t4_second_issued", o_issued, 1'b1);
    chk("t4_second_rob", o_data_out.rob_index, 5'd1);
    tick();
    chk("t4_idle", o_issued, 1'b0);
    do_reset();

    // 5: flush window (3, 8) squashes rob 5 and 7, drops concurrent dispatch
    i_rob_head = 5'd2;
    i_fu_ready = 1'b0;
    dispatch(mk(8, 60, 0, 1'b1, 1'b1, 2));
    dispatch(mk(8, 61, 0, 1'b1, 1'b1, 3));
    dispatch(mk(8, 62, 0, 1'b1, 1'b1, 5));
    dispatch(mk(8, 63, 0, 1'b1, 1'b1, 7));
    i_mispredict     = 1'b1;
    i_mispredict_tag = 5'd3;
    i_curr_rob_tag   = 5'd8;
    dispatch(mk(9, 64, 0, 1'b1, 1'b1, 8));
    i_mispredict = 1'b0;
    chk("t5_flush_no_issue", o_issued, 1'b0);
    chk("t5_flush_rs_ready", o_rs_ready, 1'b1);
    for (int k = 0; k < 6; k++) begin
      dispatch(mk(10, 70 + k, 0, 1'b0, 1'b1, 8 + k));
      chk("t5_refill_rs_ready", o_rs_ready, (k < 5) ? 1'b1 : 1'b0);
    end
    exp_q.push_back(as_issued(mk(8, 60, 0, 1'b1, 1'b1, 2)));
    exp_q.push_back(as_issued(mk(8, 61, 0, 1'b1, 1'b1, 3)));
    i_fu_ready = 1'b1;
    tick();
    chk("t5_survivor1", o_issued, 1'b1);
    chk("t5_rs_ready_after_issue", o_rs_ready, 1'b1);
    tick();
    chk("t5_survivor2", o_issued, 1'b1);
    tick();
    chk("t5_no_squashed_issue", o_issued, 1'b0);
    do_reset();

    // 6: fu_ready stall, then oldest first; reset mid-stream kills pending issue
    i_rob_head = '0;
    i_fu_ready = 1'b0;
    d_a = mk(11, 80, 81, 1'b1, 1'b1, 2);
    d_b = mk(12, 82, 83, 1'b1, 1'b1, 1);
    dispatch(d_a);
    dispatch(d_b);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t6_stall", o_issued, 1'b0);
    end
    exp_q.push_back(as_issued(d_b));
    exp_q.push_back(as_issued(d_a));
    i_fu_ready = 1'b1;
    tick();
    chk("t6_first", o_issued, 1'b1);
    chk("t6_first_rob", o_data_out.rob_index, 5'd1);
    tick();
    chk("t6_second", o_issued, 1'b1);
    chk("t6_second_rob", o_data_out.rob_index, 5'd2);
    tick();
    chk("t6_idle", o_issued, 1'b0);
    d_a = mk(13, 84, 0, 1'b1, 1'b1, 5);
    d_b = mk(14, 85, 0, 1'b1, 1'b1, 6);
    exp_q.push_back(as_issued(d_a));
    dispatch(d_a);
    dispatch(d_b);
    chk("t6_stream_issue", o_issued, 1'b1);
    reset = 1'b1;
    tick();
    chk("t6_rst_issued", o_issued, 1'b0);
    chk("t6_rst_data_out", o_data_out, '0);
    reset = 1'b0;
    tick();
    chk("t6_post_rst_issued", o_issued, 1'b0);
    chk("t6_post_rst_rs_ready", o_rs_ready, 1'b1);
    tick();
    chk("t6_post_rst_idle", o_issued, 1'b0);

    // Every expected issue must have been observed
    chk("final_queue_empty", 96'(exp_q.size()), 96'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
